// File: rtl/ternary_neuron_stream.sv
// ternary_neuron_stream: streamed ternary-weight MAC neuron with a saturating
// accumulator, signed bias and sign activation.
module ternary_neuron_stream #(
   parameter int N_INPUTS = 64,
   parameter int IN_W     = 2,
   parameter int ACC_W    = 8,
   parameter int BIAS_W   = 4,
   parameter int ACT_MODE = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        abort,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [IN_W-1:0]             input_val,
   input  logic [1:0]                  weight,
   input  logic [BIAS_W-1:0]           bias,
   output logic [$clog2(N_INPUTS)-1:0] idx_out,
   output logic                        busy,
   output logic                        done,
   output logic [ACC_W-1:0]            result,
   output logic [1:0]                  act_out,
   output logic                        sat_flag
);
   localparam int IDX_W = $clog2(N_INPUTS);

   typedef enum logic [1:0] {IDLE, ACCUM, BIAS, DONE} state_t;

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [ACC_W:0]   mag;
   logic [ACC_W:0]   acc_sum;
   logic [ACC_W:0]   bias_sum;
   logic [ACC_W-1:0] acc_clip;
   logic [ACC_W-1:0] bias_clip;
   logic             acc_ovf;
   logic             bias_ovf;
   logic             last;
   logic [1:0]       act_n;

   // one bit of headroom: overflow shows up as disagreeing top two bits
   function automatic logic [ACC_W-1:0] clamp(input logic [ACC_W:0] v);
      return (v[ACC_W] != v[ACC_W-1]) ? {v[ACC_W], {(ACC_W-1){~v[ACC_W]}}} : v[ACC_W-1:0];
   endfunction

   always_comb begin
      mag       = {{(ACC_W+1-IN_W){1'b0}}, input_val};
      acc_sum   = {acc[ACC_W-1], acc} + (weight == 2'b01 ? mag : weight == 2'b11 ? -mag : '0);
      bias_sum  = {acc[ACC_W-1], acc} + {{(ACC_W+1-BIAS_W){bias[BIAS_W-1]}}, bias};
      acc_ovf   = acc_sum[ACC_W] != acc_sum[ACC_W-1];
      bias_ovf  = bias_sum[ACC_W] != bias_sum[ACC_W-1];
      acc_clip  = clamp(acc_sum);
      bias_clip = clamp(bias_sum);
      act_n     = (ACT_MODE == 1 && bias_clip == '0) ? 2'b00 : bias_clip[ACC_W-1] ? 2'b11 : 2'b01;
      last      = idx_out == IDX_W'(N_INPUTS - 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         acc      <= '0;
         idx_out  <= '0;
         result   <= '0;
         act_out  <= 2'b00;
         sat_flag <= 1'b0;
      end else if (abort) begin
         state   <= IDLE;
         acc     <= '0;
         idx_out <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               acc      <= '0;
               idx_out  <= '0;
               sat_flag <= 1'b0;
               state    <= ACCUM;
            end
            ACCUM: if (in_valid) begin
               acc      <= acc_clip;
               sat_flag <= sat_flag | acc_ovf;
               idx_out  <= last ? '0 : idx_out + 1'b1;
               if (last) state <= BIAS;
            end
            BIAS: begin
               result   <= bias_clip;
               act_out  <= act_n;
               sat_flag <= sat_flag | bias_ovf;
               state    <= DONE;
            end
            default: if (!start) state <= IDLE;
         endcase
      end
   end

   assign in_ready = state == ACCUM;
   assign busy     = state == ACCUM || state == BIAS;
   assign done     = state == DONE;
endmodule
